// File: rtl/reg_file_mp.sv
// Multi-port register file: two prioritised write ports, optional write-to-read bypass,
// per-register pending-load scoreboard and a protected, fetch-refreshed PC register.
module reg_file_mp #(
  parameter int unsigned N        = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned AW       = $clog2(NUM_REGS),
  parameter int unsigned NUM_READ = 3,
  parameter int unsigned PC_IDX   = NUM_REGS - 1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n_i,
  input  logic [NUM_READ*AW-1:0] raddr_i,
  output logic [NUM_READ*N-1:0]  rdata_o,
  output logic [NUM_READ-1:0]    rbusy_o,
  input  logic                   we0_i,
  input  logic [AW-1:0]          waddr0_i,
  input  logic [N-1:0]           wdata0_i,
  input  logic                   we1_i,
  input  logic [AW-1:0]          waddr1_i,
  input  logic [N-1:0]           wdata1_i,
  input  logic                   reserve_i,
  input  logic [AW-1:0]          reserve_addr_i,
  input  logic [N-1:0]           pc_i,
  output logic                   pc_err_o
);

  localparam logic [AW-1:0] PcAddr = AW'(PC_IDX);

  logic [N-1:0]        regs_q [NUM_REGS];
  logic [N-1:0]        regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                pc_err_q, pc_err_d;

  logic wr0_pc, wr1_pc, rsv_pc;

  assign wr0_pc = we0_i && (waddr0_i == PcAddr);
  assign wr1_pc = we1_i && (waddr1_i == PcAddr);
  assign rsv_pc = reserve_i && (reserve_addr_i == PcAddr);

  always_comb begin
    regs_d   = regs_q;
    pend_d   = pend_q;
    pc_err_d = pc_err_q | wr0_pc | wr1_pc | rsv_pc;
    if (we0_i && !wr0_pc) regs_d[waddr0_i] = wdata0_i;
    // Port 1 is applied after port 0 so it wins a same-address collision.
    if (we1_i && !wr1_pc) begin
      regs_d[waddr1_i] = wdata1_i;
      pend_d[waddr1_i] = 1'b0;
    end
    // A new reservation overrides a same-cycle load return.
    if (reserve_i && !rsv_pc) pend_d[reserve_addr_i] = 1'b1;
    regs_d[PcAddr] = pc_i;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      pend_q   <= '0;
      pc_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      pend_q   <= pend_d;
      pc_err_q <= pc_err_d;
    end
  end

  assign pc_err_o = pc_err_q;

  for (genvar k = 0; k < int'(NUM_READ); k++) begin : g_rd
    logic [AW-1:0] ra;
    logic [N-1:0]  rd;
    logic          rb;

    assign ra = raddr_i[k*AW +: AW];

    always_comb begin
      rd = regs_q[ra];
      rb = pend_q[ra];
      if (BYPASS && (ra != PcAddr)) begin
        if (we0_i && (waddr0_i == ra)) rd = wdata0_i;
        if (we1_i && (waddr1_i == ra)) begin
          rd = wdata1_i;
          rb = 1'b0;
        end
      end
      if (ra == PcAddr) rb = 1'b0;
    end

    assign rdata_o[k*N +: N] = rd;
    assign rbusy_o[k]        = rb;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a bypassing and a non-bypassing instance share stimulus.
module tb_reg_file_mp;

  localparam int unsigned N = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned NR = 3;

  logic              clk;
  logic              rst_n_i;
  logic [NR*AW-1:0]  raddr_i;
  logic [NR*N-1:0]   rdata_b, rdata_n;
  logic [NR-1:0]     rbusy_b, rbusy_n;
  logic              we0_i, we1_i, reserve_i;
  logic [AW-1:0]     waddr0_i, waddr1_i, reserve_addr_i;
  logic [N-1:0]      wdata0_i, wdata1_i, pc_i;
  logic              err_b, err_n;

  int checks = 0;
  int failures = 0;

  reg_file_mp #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst_n_i(rst_n_i), .raddr_i(raddr_i), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
    .we0_i(we0_i), .waddr0_i(waddr0_i), .wdata0_i(wdata0_i),
    .we1_i(we1_i), .waddr1_i(waddr1_i), .wdata1_i(wdata1_i),
    .reserve_i(reserve_i), .reserve_addr_i(reserve_addr_i), .pc_i(pc_i), .pc_err_o(err_b)
  );

  reg_file_mp #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n_i(rst_n_i), .raddr_i(raddr_i), .rdata_o(rdata_n), .rbusy_o(rbusy_n),
    .we0_i(we0_i), .waddr0_i(waddr0_i), .wdata0_i(wdata0_i),
    .we1_i(we1_i), .waddr1_i(waddr1_i), .wdata1_i(wdata1_i),
    .reserve_i(reserve_i), .reserve_addr_i(reserve_addr_i), .pc_i(pc_i), .pc_err_o(err_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we0;
    logic [3:0]  a0;
    logic [31:0] d0;
    logic        we1;
    logic [3:0]  a1;
    logic [31:0] d1;
    logic        rsv;
    logic [3:0]  ra;
    logic [3:0]  p [3];
    logic [31:0] x [3];
    logic [31:0] xnb;
    logic [2:0]  xbusy;
    logic        xerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit we0, input int a0, input logic [31:0] d0,
                              input bit we1, input int a1, input logic [31:0] d1,
                              input bit rsv, input int ra, input int p0, input int p1,
                              input int p2, input logic [31:0] x0, input logic [31:0] x1,
                              input logic [31:0] x2, input logic [31:0] xnb,
                              input logic [2:0] xbusy, input bit xerr);
    vec_t v;
    v.we0 = we0; v.a0 = 4'(a0); v.d0 = d0;
    v.we1 = we1; v.a1 = 4'(a1); v.d1 = d1;
    v.rsv = rsv; v.ra = 4'(ra);
    v.p[0] = 4'(p0); v.p[1] = 4'(p1); v.p[2] = 4'(p2);
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2;
    v.xnb = xnb; v.xbusy = xbusy; v.xerr = xerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    we0_i = 1'b0; waddr0_i = '0; wdata0_i = '0;
    we1_i = 1'b0; waddr1_i = '0; wdata1_i = '0;
    reserve_i = 1'b0; reserve_addr_i = '0;
  endtask

  task automatic rd_all(input int a);
    raddr_i = {4'(a), 4'(a), 4'(a)};
  endtask

  logic [31:0] exp_pc;

  initial begin
    rst_n_i = 1'b0;
    pc_i = 32'h100;
    idle();
    rd_all(0);

    // Reset: every register reads zero, nothing busy, no error.
    for (int r = 0; r < 16; r++) begin
      rd_all(r);
      #1;
      chk($sformatf("reset_rdata_r%0d", r), rdata_b[0 +: 32], 32'h0);
      chk($sformatf("reset_rbusy_r%0d", r), {29'h0, rbusy_b}, 32'h0);
    end
    chk("reset_err", {31'h0, err_b}, 32'h0);

    @(negedge clk);
    rst_n_i = 1'b1;
    @(negedge clk);
    rd_all(15);
    #1;
    chk("pc_after_reset", rdata_b[0 +: 32], 32'h100);

    //           we0 a0 d0            we1 a1 d1     rsv ra  p0 p1 p2  x0            x1            x2            xnb           busy  err
    vecs.push_back(mk(1, 3, 32'hDEADBEEF, 0, 0, 0,     0, 0,  3, 15, 0, 32'hDEADBEEF, 32'h100,      32'h0,        32'h0,        3'b000, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0,  3, 3, 3,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 0));
    vecs.push_back(mk(1, 5, 32'h11,       1, 5, 32'h22, 0, 0, 5, 6, 7,  32'h22,       32'h0,        32'h0,        32'h0,        3'b000, 0));
    vecs.push_back(mk(1, 6, 32'h33,       1, 7, 32'h44, 0, 0, 5, 6, 7,  32'h22,       32'h33,       32'h44,       32'h22,       3'b000, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0,  5, 6, 7,  32'h22,       32'h33,       32'h44,       32'h22,       3'b000, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,     1, 2,  2, 2, 3,  32'h0,        32'h0,        32'hDEADBEEF, 32'h0,        3'b000, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0,  2, 3, 15, 32'h0,        32'hDEADBEEF, 32'h100,      32'h0,        3'b001, 0));
    vecs.push_back(mk(0, 0, 0,            1, 2, 32'h55, 0, 0, 2, 2, 2,  32'h55,       32'h55,       32'h55,       32'h0,        3'b000, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0,  2, 4, 4,  32'h55,       32'h0,        32'h0,        32'h55,       3'b000, 0));
    vecs.push_back(mk(0, 0, 0,            1, 2, 32'h66, 1, 2, 2, 4, 4,  32'h66,       32'h0,        32'h0,        32'h55,       3'b000, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0,  2, 4, 4,  32'h66,       32'h0,        32'h0,        32'h66,       3'b001, 0));
    vecs.push_back(mk(1, 15, 32'hFFFF,    0, 0, 0,     0, 0,  15, 15, 15, 32'h100,    32'h100,      32'h100,      32'h100,      3'b000, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0,  15, 15, 15, 32'h100,    32'h100,      32'h100,      32'h100,      3'b000, 1));

    foreach (vecs[i]) begin
      @(negedge clk);
      we0_i = vecs[i].we0; waddr0_i = vecs[i].a0; wdata0_i = vecs[i].d0;
      we1_i = vecs[i].we1; waddr1_i = vecs[i].a1; wdata1_i = vecs[i].d1;
      reserve_i = vecs[i].rsv; reserve_addr_i = vecs[i].ra;
      raddr_i = {vecs[i].p[2], vecs[i].p[1], vecs[i].p[0]};
      #1;
      for (int k = 0; k < 3; k++)
        chk($sformatf("vec%0d_rdata%0d", i, k), rdata_b[k*32 +: 32], vecs[i].x[k]);
      chk($sformatf("vec%0d_nobypass_rdata0", i), rdata_n[0 +: 32], vecs[i].xnb);
      chk($sformatf("vec%0d_rbusy", i), {29'h0, rbusy_b}, {29'h0, vecs[i].xbusy});
      chk($sformatf("vec%0d_pc_err", i), {31'h0, err_b}, {31'h0, vecs[i].xerr});
    end

    // pc_err is sticky; PC keeps tracking pc_i.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      idle();
      pc_i = 32'h200;
      rd_all(15);
      exp_pc = (c == 0) ? 32'h100 : 32'h200;
      #1;
      chk($sformatf("idle%0d_pc_err", c), {31'h0, err_b}, 32'h1);
      chk($sformatf("idle%0d_pc", c), rdata_b[0 +: 32], exp_pc);
    end

    // Reset clears pc_err; reserving the PC sets it again.
    @(negedge clk);
    rst_n_i = 1'b0;
    #1;
    chk("rst_clears_pc_err", {31'h0, err_b}, 32'h0);
    @(negedge clk);
    rst_n_i = 1'b1;
    @(negedge clk);
    reserve_i = 1'b1; reserve_addr_i = 4'd15;
    rd_all(15);
    #1;
    chk("rsv_pc_err_before_edge", {31'h0, err_b}, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("rsv_pc_err_after_edge", {31'h0, err_b}, 32'h1);
    chk("rsv_pc_not_busy", {29'h0, rbusy_b}, 32'h0);

    // Asynchronous reset between edges wipes data, pending and error.
    @(negedge clk);
    we0_i = 1'b1; waddr0_i = 4'd4; wdata0_i = 32'h77;
    reserve_i = 1'b1; reserve_addr_i = 4'd4;
    @(negedge clk);
    idle();
    rd_all(4);
    #1;
    chk("async_pre_rdata", rdata_b[0 +: 32], 32'h77);
    chk("async_pre_rbusy", {29'h0, rbusy_b}, 32'h7);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("async_rdata", rdata_b[0 +: 32], 32'h0);
    chk("async_rbusy", {29'h0, rbusy_b}, 32'h0);
    chk("async_pc_err", {31'h0, err_b}, 32'h0);
    chk("async_nobypass_rdata", rdata_n[0 +: 32], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
